// File: rtl/lcd_fb_reader_pkg.sv
// rtl/lcd_fb_reader_pkg.sv - shared SDRAM width and default LCD timing constants
package lcd_fb_reader_pkg;

    localparam int SDRAM_DATA_WIDTH = 16;
    localparam int ADDR_W           = 24;
    localparam int CNT_W            = 12;

    localparam int LCD_H_SYNC   = 128;
    localparam int LCD_H_BP     = 88;
    localparam int LCD_H_ACTIVE = 800;
    localparam int LCD_H_FP     = 40;
    localparam int LCD_V_SYNC   = 2;
    localparam int LCD_V_BP     = 33;
    localparam int LCD_V_ACTIVE = 480;
    localparam int LCD_V_FP     = 10;
    localparam int LCD_BURST    = 256;
    localparam int LCD_LOAD_CYC = 8;

    // End address may wrap past the top of the 24-bit space.
    function automatic logic [ADDR_W-1:0] fb_end_addr(input logic [ADDR_W-1:0] base,
                                                      input int words);
        return base + ADDR_W'(words);
    endfunction

endpackage

// File: rtl/lcd_timing_gen.sv
// rtl/lcd_timing_gen.sv - h/v counters, active window and raw active-low syncs
module lcd_timing_gen
    import lcd_fb_reader_pkg::*;
#(
    parameter int H_SYNC   = LCD_H_SYNC,
    parameter int H_BP     = LCD_H_BP,
    parameter int H_ACTIVE = LCD_H_ACTIVE,
    parameter int H_FP     = LCD_H_FP,
    parameter int V_SYNC   = LCD_V_SYNC,
    parameter int V_BP     = LCD_V_BP,
    parameter int V_ACTIVE = LCD_V_ACTIVE,
    parameter int V_FP     = LCD_V_FP
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic [CNT_W-1:0] h_cnt,
    output logic [CNT_W-1:0] v_cnt,
    output logic             h_last,
    output logic             v_last,
    output logic             act,
    output logic             hs_raw,
    output logic             vs_raw
);

    localparam logic [CNT_W-1:0] H_END = CNT_W'(H_SYNC + H_BP + H_ACTIVE + H_FP - 1);
    localparam logic [CNT_W-1:0] V_END = CNT_W'(V_SYNC + V_BP + V_ACTIVE + V_FP - 1);
    localparam logic [CNT_W-1:0] H_A0  = CNT_W'(H_SYNC + H_BP);
    localparam logic [CNT_W-1:0] H_A1  = CNT_W'(H_SYNC + H_BP + H_ACTIVE);
    localparam logic [CNT_W-1:0] V_A0  = CNT_W'(V_SYNC + V_BP);
    localparam logic [CNT_W-1:0] V_A1  = CNT_W'(V_SYNC + V_BP + V_ACTIVE);
    localparam logic [CNT_W-1:0] H_S   = CNT_W'(H_SYNC);
    localparam logic [CNT_W-1:0] V_S   = CNT_W'(V_SYNC);

    assign h_last = (h_cnt == H_END);
    assign v_last = (v_cnt == V_END);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (!en) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else begin
            h_cnt <= h_last ? '0 : h_cnt + 1'b1;
            if (h_last)
                v_cnt <= v_last ? '0 : v_cnt + 1'b1;
        end
    end

    assign act    = (h_cnt >= H_A0) && (h_cnt < H_A1) && (v_cnt >= V_A0) && (v_cnt < V_A1);
    assign hs_raw = (h_cnt >= H_S);
    assign vs_raw = (v_cnt >= V_S);

endmodule

// File: rtl/lcd_fb_reader.sv
// rtl/lcd_fb_reader.sv - streams a frame buffer from the SDRAM read port to an RGB LCD
module lcd_fb_reader
    import lcd_fb_reader_pkg::*;
#(
    parameter int DATA_W   = SDRAM_DATA_WIDTH,
    parameter int H_SYNC   = LCD_H_SYNC,
    parameter int H_BP     = LCD_H_BP,
    parameter int H_ACTIVE = LCD_H_ACTIVE,
    parameter int H_FP     = LCD_H_FP,
    parameter int V_SYNC   = LCD_V_SYNC,
    parameter int V_BP     = LCD_V_BP,
    parameter int V_ACTIVE = LCD_V_ACTIVE,
    parameter int V_FP     = LCD_V_FP,
    parameter int BURST    = LCD_BURST,
    parameter int LOAD_CYC = LCD_LOAD_CYC
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sdram_init_done,
    input  logic [23:0]       fb_base,
    input  logic [DATA_W-1:0] rd_data,
    output logic              rd_en,
    output logic              rd_load,
    output logic              sdram_read_valid,
    output logic [23:0]       rd_min_addr,
    output logic [23:0]       rd_max_addr,
    output logic [9:0]        rd_len,
    output logic              lcd_hs,
    output logic              lcd_vs,
    output logic              lcd_de,
    output logic [DATA_W-1:0] lcd_rgb,
    output logic              frame_done
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RUN} state_t;

    localparam logic [CNT_W-1:0] LOAD_END   = CNT_W'(LOAD_CYC);
    localparam logic [CNT_W-1:0] H_LAST_ACT = CNT_W'(H_SYNC + H_BP + H_ACTIVE - 1);
    localparam logic [CNT_W-1:0] V_LAST_ACT = CNT_W'(V_SYNC + V_BP + V_ACTIVE - 1);

    state_t           state;
    logic             init_m, init_s;
    logic [CNT_W-1:0] h_cnt, v_cnt;
    logic             h_last, v_last, act, hs_raw, vs_raw;
    logic             run, last_pix;
    logic             de_d1, hs_d1, vs_d1, lp1, lp2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            init_m <= 1'b0;
            init_s <= 1'b0;
        end else begin
            init_m <= sdram_init_done;
            init_s <= init_m;
        end
    end

    lcd_timing_gen #(
        .H_SYNC(H_SYNC), .H_BP(H_BP), .H_ACTIVE(H_ACTIVE), .H_FP(H_FP),
        .V_SYNC(V_SYNC), .V_BP(V_BP), .V_ACTIVE(V_ACTIVE), .V_FP(V_FP)
    ) u_timing (
        .clk(clk), .rst_n(rst_n), .en((state != S_IDLE) && init_s),
        .h_cnt(h_cnt), .v_cnt(v_cnt), .h_last(h_last), .v_last(v_last),
        .act(act), .hs_raw(hs_raw), .vs_raw(vs_raw)
    );

    // Gating with init_s stops reads the moment the synchronized init drops.
    assign run      = (state == S_RUN) && init_s;
    assign rd_en    = run && act;
    assign rd_load  = run && (v_cnt == '0) && (h_cnt < LOAD_END);
    assign rd_len   = 10'(BURST);
    assign last_pix = rd_en && (h_cnt == H_LAST_ACT) && (v_cnt == V_LAST_ACT);

    // RUN is entered exactly as the counters wrap, so the first RUN frame is a full one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= S_IDLE;
            sdram_read_valid <= 1'b0;
        end else if (!init_s) begin
            state            <= S_IDLE;
            sdram_read_valid <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    state            <= S_WAIT;
                    sdram_read_valid <= 1'b1;
                end
                S_WAIT: if (h_last && v_last) state <= S_RUN;
                S_RUN:  state <= S_RUN;
                default: begin
                    state            <= S_IDLE;
                    sdram_read_valid <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_min_addr <= '0;
            rd_max_addr <= '0;
        end else if (rd_load && (h_cnt == '0)) begin
            rd_min_addr <= fb_base;
            rd_max_addr <= fb_end_addr(fb_base, H_ACTIVE * V_ACTIVE);
        end
    end

    // Two-stage output pipeline: rd_data arrives one clock after rd_en, then is registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            de_d1 <= 1'b0; lcd_de <= 1'b0; lcd_rgb <= '0;
            hs_d1 <= 1'b1; lcd_hs <= 1'b1;
            vs_d1 <= 1'b1; lcd_vs <= 1'b1;
            lp1 <= 1'b0; lp2 <= 1'b0; frame_done <= 1'b0;
        end else if (!init_s) begin
            de_d1 <= 1'b0; lcd_de <= 1'b0; lcd_rgb <= '0;
            hs_d1 <= 1'b1; lcd_hs <= 1'b1;
            vs_d1 <= 1'b1; lcd_vs <= 1'b1;
            lp1 <= 1'b0; lp2 <= 1'b0; frame_done <= 1'b0;
        end else begin
            de_d1      <= rd_en;
            lcd_de     <= de_d1;
            lcd_rgb    <= de_d1 ? rd_data : '0;
            hs_d1      <= (state == S_IDLE) || hs_raw;
            lcd_hs     <= hs_d1;
            vs_d1      <= (state == S_IDLE) || vs_raw;
            lcd_vs     <= vs_d1;
            lp1        <= last_pix;
            lp2        <= lp1;
            frame_done <= lp2 && (state == S_RUN);
        end
    end

endmodule

// File: tb/tb_lcd_fb_reader.sv
// tb/tb_lcd_fb_reader.sv - directed scoreboard bench for lcd_fb_reader on a small panel
module tb_lcd_fb_reader;

    localparam int HT = 14;
    localparam int FT = 98;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sdram_init_done = 1'b0;
    logic [23:0] fb_base = 24'hFFFFF0;
    logic [15:0] rd_data = '0;
    logic        rd_en, rd_load, sdram_read_valid, lcd_hs, lcd_vs, lcd_de, frame_done;
    logic [23:0] rd_min_addr, rd_max_addr;
    logic [9:0]  rd_len;
    logic [15:0] lcd_rgb;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lcd_fb_reader #(
        .DATA_W(16), .H_SYNC(2), .H_BP(2), .H_ACTIVE(8), .H_FP(2),
        .V_SYNC(1), .V_BP(1), .V_ACTIVE(4), .V_FP(1), .BURST(16), .LOAD_CYC(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .sdram_init_done(sdram_init_done), .fb_base(fb_base),
        .rd_data(rd_data), .rd_en(rd_en), .rd_load(rd_load),
        .sdram_read_valid(sdram_read_valid), .rd_min_addr(rd_min_addr),
        .rd_max_addr(rd_max_addr), .rd_len(rd_len), .lcd_hs(lcd_hs), .lcd_vs(lcd_vs),
        .lcd_de(lcd_de), .lcd_rgb(lcd_rgb), .frame_done(frame_done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // FIFO model: flushed by rd_load, returns an incrementing count one clock after rd_en.
    logic [15:0] fifo_cnt = '0;
    always @(posedge clk) begin
        if (rd_load) fifo_cnt <= '0;
        else if (rd_en) begin
            rd_data  <= fifo_cnt;
            fifo_cnt <= fifo_cnt + 1'b1;
        end
    end

    bit          mon_on = 0, pos_ok = 0, load_prev = 0, prev_de = 0;
    bit          en_h1 = 0, en_h2 = 0, hs_e1 = 1, hs_e2 = 1, vs_e1 = 1, vs_e2 = 1, sv1 = 0, sv2 = 0;
    int          pos = 0, mh = 0, mv = 0, exp_cnt = 0, de_cnt = 0, fd_seen = 0;
    logic [15:0] sb[$];
    logic [15:0] exp_px;
    bit          exp_fd;

    always @(posedge clk) begin
        #1;
        if (!mon_on) begin
            pos_ok = 0; load_prev = 0; prev_de = 0; en_h1 = 0; en_h2 = 0;
            sv1 = 0; sv2 = 0; exp_cnt = 0; de_cnt = 0;
            sb.delete();
        end else begin
            if (rd_load && !load_prev) begin
                pos = 0;
                pos_ok = 1;
            end else if (pos_ok) pos = (pos + 1) % FT;
            load_prev = rd_load;
            mh = pos % HT;
            mv = pos / HT;
            if (pos_ok) begin
                chk("rd_en_pos", rd_en, (mh >= 4 && mh < 12 && mv >= 2 && mv < 6));
                chk("rd_load_pos", rd_load, (mv == 0 && mh < 4));
            end else chk("rd_en_before_load", rd_en, 0);

            if (sv2) begin
                chk("lcd_hs", lcd_hs, hs_e2);
                chk("lcd_vs", lcd_vs, vs_e2);
            end
            hs_e2 = hs_e1; vs_e2 = vs_e1; sv2 = sv1;
            hs_e1 = (mh >= 2); vs_e1 = (mv >= 1); sv1 = pos_ok;

            chk("de_vs_rd_en_d2", lcd_de, en_h2);
            en_h2 = en_h1;
            en_h1 = rd_en;

            if (lcd_de) begin
                if (sb.size() == 0) chk("sb_underrun", 0, 1);
                else begin
                    exp_px = sb.pop_front();
                    chk("lcd_rgb", lcd_rgb, exp_px);
                end
            end else chk("rgb_zero_no_de", lcd_rgb, 0);

            exp_fd = prev_de && (de_cnt == 32);
            chk("frame_done", frame_done, exp_fd);
            if (exp_fd) begin
                chk("px_per_frame", exp_cnt, 32);
                de_cnt = 0;
            end
            if (lcd_de) de_cnt++;
            prev_de = lcd_de;

            if (rd_load) exp_cnt = 0;
            else if (rd_en) begin
                sb.push_back(exp_cnt[15:0]);
                exp_cnt++;
            end
        end
        if (frame_done) fd_seen++;
    end

    task automatic wait_load(input string tag, output int n);
        n = 0;
        while (!rd_load && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!rd_load) chk(tag, 0, 1);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_rd_en"}, rd_en, 0);
        chk({tag, "_rd_load"}, rd_load, 0);
        chk({tag, "_read_valid"}, sdram_read_valid, 0);
        chk({tag, "_de"}, lcd_de, 0);
        chk({tag, "_hs"}, lcd_hs, 1);
        chk({tag, "_vs"}, lcd_vs, 1);
        chk({tag, "_rgb"}, lcd_rgb, 0);
        chk({tag, "_frame_done"}, frame_done, 0);
    endtask

    int n, lat, fd_base;

    initial begin
        repeat (3) @(negedge clk);
        chk_idle("reset");
        chk("reset_min", rd_min_addr, 0);
        chk("reset_max", rd_max_addr, 0);
        chk("rd_len", rd_len, 16);

        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("pre_init_valid", sdram_read_valid, 0);
        chk("pre_init_rd_en", rd_en, 0);

        sdram_init_done = 1'b1;
        mon_on = 1;
        lat = 0;
        while (!sdram_read_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        chk("valid_latency", (lat >= 2 && lat <= 3), 1);

        wait_load("first_load_timeout", n);
        chk("first_load_delay", n, FT);
        @(negedge clk);
        chk("min_wrap", rd_min_addr, 24'hFFFFF0);
        chk("max_wrap", rd_max_addr, 24'h000010);

        repeat (30) @(negedge clk);
        fb_base = 24'h000100;
        repeat (10) @(negedge clk);
        chk("min_held", rd_min_addr, 24'hFFFFF0);
        chk("max_held", rd_max_addr, 24'h000010);
        wait_load("second_load_timeout", n);
        @(negedge clk);
        chk("min_next", rd_min_addr, 24'h000100);
        chk("max_next", rd_max_addr, 24'h000120);
        repeat (97) @(negedge clk);
        chk("frames_done", fd_seen, 2);

        n = 0;
        while (!rd_en && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("mid_line_rd_en", rd_en, 1);
        sdram_init_done = 1'b0;
        mon_on = 0;
        repeat (3) @(negedge clk);
        chk_idle("init_drop");

        sdram_init_done = 1'b1;
        mon_on = 1;
        fd_base = fd_seen;
        wait_load("reinit_load_timeout", n);
        repeat (FT) @(negedge clk);
        chk("reinit_frame", fd_seen, fd_base + 1);

        n = 0;
        while (!lcd_de && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("mid_line_de", lcd_de, 1);
        #2;
        rst_n = 1'b0;
        mon_on = 0;
        #1;
        chk_idle("async_rst");
        chk("async_rst_min", rd_min_addr, 0);
        chk("async_rst_max", rd_max_addr, 0);
        @(negedge clk);
        rst_n = 1'b1;
        mon_on = 1;
        fd_base = fd_seen;
        wait_load("post_rst_load_timeout", n);
        @(negedge clk);
        chk("post_rst_min", rd_min_addr, 24'h000100);
        repeat (FT - 1) @(negedge clk);
        chk("post_rst_frame", fd_seen, fd_base + 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
